uart_tx: RTL

- Serial transmitter that drives the processor's `tx` line; it is the transmit end of the UART link whose receive end feeds `rx`.
- Accepts bytes from the debug/dump logic through a valid/ready handshake.
- Buffers them in a small FIFO and serialises each one as 8N1: LSB first, one start bit, one stop bit, no parity.
- Bit timing comes from an internal cycle counter; no external baud tick is used.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART encodings and board-clock defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uartState_t;

  // 50 MHz board clock at 115200 baud
  localparam int CLKS_PER_BIT = 434;
  localparam int DATA_BITS    = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read; pointers wrap modulo DEPTH (power of 2).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte input, FIFO buffering, internal bit timing.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uartState_t           state, stateNext;
  logic [CW-1:0]        cyc, cycNext;
  logic [BW-1:0]        bitIdx, bitNext;
  logic [DATA_BITS-1:0] shift, shiftNext;
  logic                 txNext;
  logic                 pop, bitEnd;
  logic [DATA_BITS-1:0] fifoDout;
  logic                 fifoFull, fifoEmpty;
  logic [AW:0]          fifoCount;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign tx_ready = !fifoFull;
  assign busy     = (state != ST_IDLE) || (fifoCount != '0);
  assign bitEnd   = (cyc == CYC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cyc    <= '0;
      bitIdx <= '0;
      shift  <= '0;
      tx     <= 1'b1;
    end else begin
      state  <= stateNext;
      cyc    <= cycNext;
      bitIdx <= bitNext;
      shift  <= shiftNext;
      tx     <= txNext;
    end
  end

  // tx is computed one cycle ahead so the registered line changes exactly on bit boundaries.
  always_comb begin
    stateNext = state;
    cycNext   = cyc;
    bitNext   = bitIdx;
    shiftNext = shift;
    txNext    = tx;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        txNext = 1'b1;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shiftNext = fifoDout;
          cycNext   = '0;
          stateNext = ST_START;
          txNext    = 1'b0;
        end
      end
      ST_START: begin
        if (bitEnd) begin
          cycNext   = '0;
          bitNext   = '0;
          stateNext = ST_DATA;
          txNext    = shift[0];
        end else begin
          cycNext = cyc + 1'b1;
        end
      end
      ST_DATA: begin
        if (bitEnd) begin
          cycNext   = '0;
          shiftNext = shift >> 1;
          if (bitIdx == BIT_LAST) begin
            stateNext = ST_STOP;
            txNext    = 1'b1;
          end else begin
            bitNext = bitIdx + 1'b1;
            txNext  = shiftNext[0];
          end
        end else begin
          cycNext = cyc + 1'b1;
        end
      end
      ST_STOP: begin
        if (bitEnd) begin
          cycNext = '0;
          // Queued byte starts straight after the stop bit, no idle gap.
          if (!fifoEmpty) begin
            pop       = 1'b1;
            shiftNext = fifoDout;
            stateNext = ST_START;
            txNext    = 1'b0;
          end else begin
            stateNext = ST_IDLE;
            txNext    = 1'b1;
          end
        end else begin
          cycNext = cyc + 1'b1;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        txNext    = 1'b1;
      end
    endcase
  end

endmodule
